// File: rtl/somador_pkg.sv
// Shared types and constants for the add/subtract + seven-segment display controller.
package somador_pkg;

    localparam int unsigned W_DADO  = 6;
    localparam int unsigned W_BCD   = 4;
    localparam int unsigned W_SEG   = 7;
    localparam int unsigned W_AN    = 3;

    localparam logic [W_BCD-1:0]  BCD_TRACO   = 4'hF;
    localparam logic [W_SEG-1:0]  SEG_APAGADO = 7'b1111111;
    localparam logic [W_SEG-1:0]  SEG_TRACO   = 7'b0111111;
    localparam logic [W_DADO-1:0] TEN         = 6'd10;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CAPTURA = 3'd1,
        SOMA    = 3'd2,
        MODULO  = 3'd3,
        BCD     = 3'd4,
        FIM     = 3'd5
    } estado_t;

endpackage

// File: rtl/decodificador_7seg.sv
// BCD digit (plus the dash code) to active-low segments, bit 0 = a ... bit 6 = g.
module decodificador_7seg
    import somador_pkg::*;
(
    input  logic [3:0] digito,
    output logic [6:0] seg
);

    // Codes 4'hA..4'hE are not produced by the controller and show blank.
    always_comb begin
        seg = SEG_APAGADO;
        case (digito)
            4'd0:      seg = 7'b1000000;
            4'd1:      seg = 7'b1111001;
            4'd2:      seg = 7'b0100100;
            4'd3:      seg = 7'b0110000;
            4'd4:      seg = 7'b0011001;
            4'd5:      seg = 7'b0010010;
            4'd6:      seg = 7'b0000010;
            4'd7:      seg = 7'b1111000;
            4'd8:      seg = 7'b0000000;
            4'd9:      seg = 7'b0010000;
            BCD_TRACO: seg = SEG_TRACO;
            default:   seg = SEG_APAGADO;
        endcase
    end

endmodule

// File: rtl/somador6bits.sv
// 6-bit ripple adder with carry in; the caller supplies the already-inverted B for subtraction.
module somador6bits
    import somador_pkg::*;
(
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       cin,
    output logic [5:0] s
);

    // Plain modulo-64 sum; overflow is judged by the caller from operand/result signs.
    always_comb begin
        s = a + b + 6'(cin);
    end

endmodule

// File: rtl/controle_somador_display.sv
// Sequenced signed 6-bit add/subtract, sign/magnitude + BCD conversion, and a
// free-running 3-digit multiplexed display scan.
// Optional feature: define OVERFLOW_DET_EN to detect overflow and show " --".
module controle_somador_display
    import somador_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       sub,
    output logic       busy,
    output logic       done,
    output logic       negativo,
    output logic       overflow,
    output logic [3:0] dezena,
    output logic [3:0] unidade,
    output logic [2:0] an,
    output logic [6:0] seg
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    estado_t estado, prox_estado;

    logic [5:0] op_a, op_b;
    logic       op_sub;
    logic [5:0] b_efetivo_c;
    logic [5:0] soma_c;
    logic [5:0] soma;
    logic [5:0] resto;
    logic [3:0] dezenas_cont;
    logic       sinal;

    assign b_efetivo_c = op_b ^ {6{op_sub}};

    somador6bits u_somador (
        .a   (op_a),
        .b   (b_efetivo_c),
        .cin (op_sub),
        .s   (soma_c)
    );

`ifdef OVERFLOW_DET_EN
    logic ovf_c;
    logic overflow_r;

    assign ovf_c    = (op_a[5] == b_efetivo_c[5]) && (soma_c[5] != op_a[5]);
    assign overflow = overflow_r;
`else
    assign overflow = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) estado <= OCIOSO;
        else     estado <= prox_estado;
    end

    // Next-state logic.
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:  if (start) prox_estado = CAPTURA;
            CAPTURA: prox_estado = SOMA;
`ifdef OVERFLOW_DET_EN
            SOMA:    prox_estado = ovf_c ? FIM : MODULO;
`else
            SOMA:    prox_estado = MODULO;
`endif
            MODULO:  prox_estado = BCD;
            BCD:     if (resto < TEN) prox_estado = FIM;
            FIM:     prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    // Operand capture, sum, magnitude and tens extraction by repeated subtraction.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a         <= '0;
            op_b         <= '0;
            op_sub       <= 1'b0;
            soma         <= '0;
            resto        <= '0;
            dezenas_cont <= '0;
            sinal        <= 1'b0;
        end else begin
            case (estado)
                CAPTURA: begin
                    op_a   <= a;
                    op_b   <= b;
                    op_sub <= sub;
                end
                SOMA: soma <= soma_c;
                MODULO: begin
                    resto        <= (soma ^ {6{soma[5]}}) + 6'(soma[5]);
                    sinal        <= soma[5];
                    dezenas_cont <= '0;
                end
                BCD: begin
                    if (resto >= TEN) begin
                        resto        <= resto - TEN;
                        dezenas_cont <= dezenas_cont + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags and result registers, loaded on the edge that enters FIM.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            negativo <= 1'b0;
            dezena   <= '0;
            unidade  <= '0;
`ifdef OVERFLOW_DET_EN
            overflow_r <= 1'b0;
`endif
        end else begin
            busy <= (prox_estado != OCIOSO);
            done <= (prox_estado == FIM);
            if (prox_estado == FIM) begin
`ifdef OVERFLOW_DET_EN
                if (estado == SOMA) begin
                    overflow_r <= 1'b1;
                    negativo   <= 1'b0;
                    dezena     <= BCD_TRACO;
                    unidade    <= BCD_TRACO;
                end else begin
                    overflow_r <= 1'b0;
                    negativo   <= sinal;
                    dezena     <= dezenas_cont;
                    unidade    <= 4'(resto);
                end
`else
                negativo <= sinal;
                dezena   <= dezenas_cont;
                unidade  <= 4'(resto);
`endif
            end
        end
    end

    // Display scan: dwell counter and digit index.
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       digito_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt   <= '0;
            digito_idx <= '0;
        end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt   <= '0;
            digito_idx <= (digito_idx == 2'd2) ? 2'd0 : digito_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    logic [3:0] digito_c;
    logic [6:0] seg_dec_c;
    logic [2:0] an_prox_c;
    logic [6:0] seg_prox_c;

    assign digito_c = (digito_idx == 2'd1) ? dezena : unidade;

    decodificador_7seg u_decod (
        .digito (digito_c),
        .seg    (seg_dec_c)
    );

    // Select enable and segment pattern for the current digit.
    always_comb begin
        an_prox_c  = 3'b111;
        seg_prox_c = SEG_APAGADO;
        case (digito_idx)
            2'd0: begin
                an_prox_c  = 3'b110;
                seg_prox_c = negativo ? SEG_TRACO : SEG_APAGADO;
            end
            2'd1: begin
                an_prox_c  = 3'b101;
                seg_prox_c = seg_dec_c;
            end
            2'd2: begin
                an_prox_c  = 3'b011;
                seg_prox_c = seg_dec_c;
            end
            default: ;
        endcase
    end

    // Registered display pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 3'b110;
            seg <= SEG_APAGADO;
        end else begin
            an  <= an_prox_c;
            seg <= seg_prox_c;
        end
    end

endmodule

// File: tb/tb_controle_somador_display.sv
// Randomized and directed bench for controle_somador_display against an arithmetic reference model.
module tb_controle_somador_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] a, b;
    logic       sub;
    logic       busy, done, negativo, overflow;
    logic [3:0] dezena, unidade;
    logic [2:0] an;
    logic [6:0] seg;

    int checks   = 0;
    int failures = 0;

    controle_somador_display #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .negativo (negativo),
        .overflow (overflow),
        .dezena   (dezena),
        .unidade  (unidade),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Reference: signed integer arithmetic, then sign/magnitude and decimal digits.
    task automatic modelo(input logic [5:0] va, input logic [5:0] vb, input logic vs,
                          output int lat, output int neg, output int ovf,
                          output int dez, output int uni);
        int sa, sb, r, w, mag;
        sa = $signed(va);
        sb = $signed(vb);
        r  = vs ? sa - sb : sa + sb;
        w  = r;
        if (w > 31)  w -= 64;
        if (w < -32) w += 64;
`ifdef OVERFLOW_DET_EN
        if (r > 31 || r < -32) begin
            lat = 3; neg = 0; ovf = 1; dez = 15; uni = 15;
            return;
        end
`endif
        neg = (w < 0) ? 1 : 0;
        mag = (w < 0) ? -w : w;
        dez = mag / 10;
        uni = mag % 10;
        lat = 5 + dez;
        ovf = 0;
    endtask

    // One operation: start in cycle t, observe cycles t+1 .. t+14.
    task automatic operar(input logic [5:0] va, input logic [5:0] vb, input logic vs,
                          input bit pulso_extra, input string tag);
        int lat, neg, ovf, dez, uni;
        int primeiro_done, n_done, erros_busy;
        logic [31:0] s_neg, s_ovf, s_dez, s_uni;
        modelo(va, vb, vs, lat, neg, ovf, dez, uni);
        @(negedge clk);
        a = va; b = vb; sub = vs; start = 1'b1;
        primeiro_done = 0; n_done = 0; erros_busy = 0;
        s_neg = '0; s_ovf = '0; s_dez = '0; s_uni = '0;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) start = 1'b0;
            if (n == 2) begin
                a = 6'($urandom); b = 6'($urandom); sub = 1'($urandom);
                if (pulso_extra) start = 1'b1;
            end
            if (n == 3) start = 1'b0;
            if (done) begin
                n_done++;
                if (primeiro_done == 0) begin
                    primeiro_done = n;
                    s_neg = 32'(negativo); s_ovf = 32'(overflow);
                    s_dez = 32'(dezena);   s_uni = 32'(unidade);
                end
            end
            if (busy !== ((n <= lat) ? 1'b1 : 1'b0)) erros_busy++;
        end
        chk({tag, " latency"}, 32'(primeiro_done), 32'(lat));
        chk({tag, " done_count"}, 32'(n_done), 32'd1);
        chk({tag, " busy_errors"}, 32'(erros_busy), 32'd0);
        chk({tag, " negativo"}, s_neg, 32'(neg));
        chk({tag, " overflow"}, s_ovf, 32'(ovf));
        chk({tag, " dezena"}, s_dez, 32'(dez));
        chk({tag, " unidade"}, s_uni, 32'(uni));
        chk({tag, " hold_unidade"}, 32'(unidade), 32'(uni));
    endtask

    initial begin
        logic [6:0] seg_traco, seg_zero, seg_sete, seg_esp;
        logic [2:0] an_ant;
        int n_trocas, ult_troca, erros_intervalo, erros_ordem, erros_seg, extra_done;

        seg_traco = ~7'b1000000;  // only g lit
        seg_zero  = ~7'b0111111;  // a..f lit
        seg_sete  = ~7'b0000111;  // a, b, c lit

        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset negativo", 32'(negativo), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset digits", {24'd0, dezena, unidade}, 32'd0);
        chk("reset an", 32'(an), 32'b110);
        chk("reset seg", 32'(seg), 32'h7F);
        @(negedge clk);
        rst = 1'b0;

        operar(6'd5, 6'd7, 1'b0, 1'b0, "add_5_7");
        operar(6'd3, 6'd10, 1'b1, 1'b0, "sub_3_10");
        operar(6'b110000, 6'b110000, 1'b0, 1'b0, "add_m16_m16");
        operar(6'd31, 6'd1, 1'b0, 1'b0, "add_31_1");
        operar(6'd5, 6'd7, 1'b0, 1'b1, "start_while_busy");
        operar(6'd0, 6'd0, 1'b0, 1'b0, "zero");
        operar(6'b100000, 6'd1, 1'b1, 1'b0, "sub_m32_1");

        for (int i = 0; i < 25; i++)
            operar(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), "random");

        // Reset during BCD of a long operation, after a -7 result is on the outputs.
        operar(6'd3, 6'd10, 1'b1, 1'b0, "pre_reset");
        @(negedge clk);
        a = 6'b110000; b = 6'b110000; sub = 1'b0; start = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) start = 1'b0;
            if (n == 4) rst = 1'b1;
        end
        chk("rst_bcd busy", 32'(busy), 32'd0);
        chk("rst_bcd done", 32'(done), 32'd0);
        chk("rst_bcd outputs", {22'd0, negativo, overflow, dezena, unidade}, 32'd0);
        rst = 1'b0;
        extra_done = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        chk("rst_bcd no_done", 32'(extra_done), 32'd0);

        // Display scan with a -7 result.
        operar(6'd3, 6'd10, 1'b1, 1'b0, "scan_setup");
        repeat (3) @(posedge clk);
        #1;
        an_ant = an; n_trocas = 0; ult_troca = -1;
        erros_intervalo = 0; erros_ordem = 0; erros_seg = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            case (an)
                3'b110:  seg_esp = seg_traco;
                3'b101:  seg_esp = seg_zero;
                3'b011:  seg_esp = seg_sete;
                default: seg_esp = 7'bx;
            endcase
            if (seg !== seg_esp) erros_seg++;
            if (an !== an_ant) begin
                if (!((an_ant == 3'b110 && an == 3'b101) ||
                      (an_ant == 3'b101 && an == 3'b011) ||
                      (an_ant == 3'b011 && an == 3'b110))) erros_ordem++;
                if (ult_troca >= 0 && (n - ult_troca) != 4) erros_intervalo++;
                ult_troca = n;
                n_trocas++;
                an_ant = an;
            end
        end
        chk("scan changes", 32'(n_trocas), 32'd10);
        chk("scan interval", 32'(erros_intervalo), 32'd0);
        chk("scan order", 32'(erros_ordem), 32'd0);
        chk("scan seg", 32'(erros_seg), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
